// File: rtl/bcd_display_pkg.sv
// Shared types and constants for the BCD 7-segment display path.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_LUT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_hex_display_seg7.sv
// One BCD digit to active-low 7-segment decoder with a blank override.
module seg7_digit
  import bcd_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd_i,
  input  logic               blank_i,
  output logic [6:0]         seg_o
);

  // Codes above 9 fall through to blank rather than showing garbage.
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i && (bcd_i <= 4'd9)) begin
      seg_o = SEG_LUT[bcd_i];
    end
  end

endmodule

// File: rtl/bcd_hex_display.sv
// Iterative double-dabble binary-to-BCD converter driving active-low 7-seg displays.
// Optional: define BCD_BLANK_LEADING_ZEROS_EN to blank digits above the most significant nonzero one.
module bcd_hex_display
  import bcd_display_pkg::*;
#(
  parameter int IN_W   = 26,
  parameter int DIGITS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_W-1:0]           in_data,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic [7*DIGITS-1:0]       hex_n,
  output logic                      done
);

  localparam int WORK_W = DIGIT_W * DIGITS;
  localparam int CNT_W  = $clog2(IN_W + 1);

  generate
    if ((IN_W >= 63) || ((64'd1 << IN_W) > pow10(DIGITS))) begin : g_bad_width
      $error("bcd_hex_display: IN_W too wide for DIGITS decimal digits");
    end
  endgenerate

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [IN_W-1:0]     shift_q, shift_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [WORK_W-1:0]   bcd_q, bcd_d;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic                done_q, done_d;
  logic [WORK_W-1:0]   work_adj;
  logic [7*DIGITS-1:0] seg_w;
  logic [DIGITS-1:0]   blank_w;

  // Per-digit add-3 stays within 4 bits; a digit >= 5 never exceeds 12.
  function automatic logic [WORK_W-1:0] add3_all(input logic [WORK_W-1:0] w);
    logic [WORK_W-1:0] r;
    r = w;
    for (int i = 0; i < DIGITS; i++) begin
      if (w[DIGIT_W*i +: DIGIT_W] >= 4'd5) begin
        r[DIGIT_W*i +: DIGIT_W] = w[DIGIT_W*i +: DIGIT_W] + 4'd3;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      shift_q <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
      hex_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      bcd_q   <= bcd_d;
      hex_q   <= hex_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (count_q == CNT_W'(1)) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    shift_d  = shift_q;
    work_d   = work_q;
    bcd_d    = bcd_q;
    hex_d    = hex_q;
    done_d   = 1'b0;
    work_adj = add3_all(work_q);
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          work_d  = '0;
          count_d = CNT_W'(IN_W);
        end
      end
      SHIFT: begin
        {work_d, shift_d} = {work_adj, shift_q} << 1;
        count_d = count_q - CNT_W'(1);
      end
      LOAD: begin
        bcd_d  = work_q;
        hex_d  = seg_w;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef BCD_BLANK_LEADING_ZEROS_EN
  // Digit i is blank when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank_w    = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (work_q[DIGIT_W*i +: DIGIT_W] == 4'd0);
      blank_w[i] = upper_zero;
    end
  end
`else
  assign blank_w = '0;
`endif

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      seg7_digit u_seg (
        .bcd_i   (work_q[DIGIT_W*g +: DIGIT_W]),
        .blank_i (blank_w[g]),
        .seg_o   (seg_w[7*g +: 7])
      );
    end
  endgenerate

  assign in_ready = (state_q == IDLE);
  assign bcd_out  = bcd_q;
  assign hex_n    = hex_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bcd_hex_display.sv
// Randomized self-checking bench for bcd_hex_display against a decimal-arithmetic model.
module tb_bcd_hex_display;

  localparam int IN_W   = 26;
  localparam int DIGITS = 8;
  localparam logic [IN_W-1:0] MAXV = {IN_W{1'b1}};
`ifdef BCD_BLANK_LEADING_ZEROS_EN
  localparam bit BLANK_LZ = 1'b1;
`else
  localparam bit BLANK_LZ = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [IN_W-1:0]     in_data;
  logic [4*DIGITS-1:0] bcd_out;
  logic [7*DIGITS-1:0] hex_n;
  logic                done;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  bcd_hex_display #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .bcd_out  (bcd_out),
    .hex_n    (hex_n),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input logic [IN_W-1:0] v);
    longint x;
    logic [4*DIGITS-1:0] r;
    x = longint'(v);
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [7*DIGITS-1:0] to_hex(input logic [IN_W-1:0] v);
    longint x;
    int d[DIGITS];
    int msd;
    logic [7*DIGITS-1:0] r;
    x = longint'(v);
    msd = 0;
    for (int i = 0; i < DIGITS; i++) begin
      d[i] = int'(x % 10);
      x = x / 10;
      if (d[i] != 0) msd = i;
    end
    for (int i = 0; i < DIGITS; i++) begin
      r[7*i +: 7] = (BLANK_LZ && i > msd) ? 7'h7F : seg_of(d[i]);
    end
    return r;
  endfunction

  // Reference model: a conversion is just a busy window of IN_W+1 cycles, then the decimal result appears.
  int                  busy;
  logic [IN_W-1:0]     pend;
  logic [4*DIGITS-1:0] exp_bcd;
  logic [7*DIGITS-1:0] exp_hex;
  logic                exp_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 0;
      pend     <= '0;
      exp_bcd  <= '0;
      exp_hex  <= '1;
      exp_done <= 1'b0;
    end else begin
      exp_done <= 1'b0;
      if (busy > 0) begin
        busy <= busy - 1;
        if (busy == 1) begin
          exp_bcd  <= to_bcd(pend);
          exp_hex  <= to_hex(pend);
          exp_done <= 1'b1;
        end
      end else if (in_valid) begin
        pend <= in_data;
        busy <= IN_W + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready", 64'(in_ready), 64'(busy == 0));
      check("done",     64'(done),     64'(exp_done));
      check("bcd_out",  64'(bcd_out),  64'(exp_bcd));
      check("hex_n",    64'(hex_n),    64'(exp_hex));
    end
  end

  task automatic send(input logic [IN_W-1:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_wait_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lowcnt);
    int n;
    n = 0;
    lowcnt = 0;
    while (!done && n < 200) begin
      if (!in_ready) lowcnt++;
      @(negedge clk);
      n++;
    end
    check("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bcd"},   64'(bcd_out),  64'd0);
    check({tag, "_hex"},   64'(hex_n),    64'h00FF_FFFF_FFFF_FFFF);
    check({tag, "_done"},  64'(done),     64'd0);
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lowcnt;
    int extra;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;

    check("model_pin_bcd", 64'(to_bcd(26'd12345)), 64'h0001_2345);
    check("model_pin_max", 64'(to_bcd(MAXV)),      64'h6710_8863);

    // Mid-cycle reset, outputs must respond without a clock edge
    #3 rst_n = 1'b0;
    #1 check_reset_values("reset0");
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    send(26'd12345);
    wait_done(lowcnt);
    check("t2_ready_low_cycles", 64'(lowcnt), 64'd27);
    check("t2_bcd",  64'(bcd_out),      64'h0001_2345);
    check("t2_dig0", 64'(hex_n[0 +: 7]),  64'h12);
    check("t2_dig4", 64'(hex_n[28 +: 7]), 64'h79);

    send(MAXV);
    wait_done(lowcnt);
    check("t3_bcd_max", 64'(bcd_out), 64'h6710_8863);
    in_valid = 1'b1;
    in_data  = '0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lowcnt);
    check("t3_bcd_zero", 64'(bcd_out),     64'd0);
    check("t3_dig0",     64'(hex_n[0 +: 7]), 64'h40);

    send(26'd500);
    repeat (4) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 26'd999;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lowcnt);
    check("t4_bcd", 64'(bcd_out), 64'h0000_0500);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("t4_no_second_done", 64'(extra), 64'd0);

    send(26'd777);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("t5_reset");
    @(negedge clk);
    rst_n = 1'b1;
    send(26'd42);
    wait_done(lowcnt);
    check("t5_bcd", 64'(bcd_out), 64'h0000_0042);
    check("t6_dig0", 64'(hex_n[0 +: 7]), 64'h24);
    check("t6_dig1", 64'(hex_n[7 +: 7]), 64'h19);
    for (int i = 2; i < DIGITS; i++) begin
      check("t6_upper_digit", 64'(hex_n[7*i +: 7]), BLANK_LZ ? 64'h7F : 64'h40);
    end

    // Random traffic: offers land both while idle and mid-conversion
    repeat (2500) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       in_data = '0;
        1:       in_data = MAXV;
        2:       in_data = IN_W'($urandom_range(0, 99));
        3:       in_data = IN_W'($urandom_range(0, 9999));
        default: in_data = IN_W'($urandom);
      endcase
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
